// File: rtl/uart_rx_frame_checksum_if.sv
// Byte-stream handshake between uart_rx, the frame checksum block and uart_tx.
// The slave modport is the checksum block's view. The master modport is the
// view of whoever surrounds it: the uart_rx/uart_tx pair or a testbench.
interface uart_rx_frame_checksum_if #(
    parameter int N_DATA_BITS = 8
) ();
    logic [N_DATA_BITS-1:0] i_rx_data;
    logic                   i_rx_data_valid;
    logic                   i_tx_ready;
    logic [N_DATA_BITS-1:0] o_tx_data;
    logic                   o_tx_valid;

    modport master (
        output i_rx_data,
        output i_rx_data_valid,
        output i_tx_ready,
        input  o_tx_data,
        input  o_tx_valid
    );

    modport slave (
        input  i_rx_data,
        input  i_rx_data_valid,
        input  i_tx_ready,
        output o_tx_data,
        output o_tx_valid
    );
endinterface

// File: rtl/uart_rx_frame_checksum.sv
// Frame checksum between uart_rx and uart_tx (uart_clk domain).
// Sums FRAME_LEN received bytes modulo 2^N_DATA_BITS. It then offers the sum
// to uart_tx over valid/ready. A partial frame is dropped when the gap between
// two bytes gets too long. A byte that arrives during the handoff is dropped,
// and that drop is flagged in a sticky overrun bit.
module uart_rx_frame_checksum #(
    parameter int N_DATA_BITS    = 8,
    parameter int FRAME_LEN      = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int CW            = $clog2(FRAME_LEN + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    uart_rx_frame_checksum_if.slave bus,
    output logic [N_DATA_BITS-1:0] o_display_data,
    output logic [CW-1:0]          o_byte_count,
    output logic                   o_frame_done,
    output logic                   o_timeout,
    output logic                   o_overrun
);
    localparam int IW = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [N_DATA_BITS-1:0] sum_q;
    logic [CW-1:0]          count_q;
    logic [IW-1:0]          idle_q;
    logic                   tx_valid_q;
    logic                   frame_done_q;
    logic                   timeout_q;
    logic                   overrun_q;

    // Next-value helpers for the ACCUM update. The carry out of the sum is
    // discarded on purpose.
    logic [N_DATA_BITS-1:0] sum_d;
    logic [CW-1:0]          count_d;
    logic [IW-1:0]          idle_d;

    assign sum_d   = sum_q + bus.i_rx_data;
    assign count_d = count_q + CW'(1);
    assign idle_d  = idle_q + IW'(1);

    // Frame FSM. It holds the sum, count, idle counter and all registered
    // outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            sum_q        <= '0;
            count_q      <= '0;
            idle_q       <= '0;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    idle_q <= '0;
                    if (bus.i_rx_data_valid) begin
                        // The first byte replaces whatever checksum was on display.
                        sum_q   <= bus.i_rx_data;
                        count_q <= CW'(1);
                        if (FRAME_LEN == 1) begin
                            state_q    <= S_SEND;
                            tx_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACCUM: begin
                    if (bus.i_rx_data_valid) begin
                        // A byte in the terminal idle cycle wins over the timeout.
                        sum_q   <= sum_d;
                        count_q <= count_d;
                        idle_q  <= '0;
                        if (count_d == COUNT_LAST) begin
                            state_q    <= S_SEND;
                            tx_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end else if (idle_q == IDLE_LAST) begin
                        state_q   <= S_IDLE;
                        sum_q     <= '0;
                        count_q   <= '0;
                        idle_q    <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        idle_q <= idle_d;
                    end
                end
                S_SEND: begin
                    idle_q <= '0;
                    // The sum and count stay frozen, so any byte here is lost.
                    if (bus.i_rx_data_valid) begin
                        overrun_q <= 1'b1;
                    end else begin
                        overrun_q <= overrun_q;
                    end
                    if (tx_valid_q && bus.i_tx_ready) begin
                        // Keep sum_q so the display still shows the checksum.
                        state_q      <= S_IDLE;
                        tx_valid_q   <= 1'b0;
                        frame_done_q <= 1'b1;
                        count_q      <= '0;
                    end else begin
                        state_q <= S_SEND;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    tx_valid_q <= 1'b0;
                    count_q    <= '0;
                    idle_q     <= '0;
                end
            endcase
        end
    end

    assign bus.o_tx_data   = sum_q;
    assign bus.o_tx_valid  = tx_valid_q;
    assign o_display_data  = sum_q;
    assign o_byte_count    = count_q;
    assign o_frame_done    = frame_done_q;
    assign o_timeout       = timeout_q;
    assign o_overrun       = overrun_q;
endmodule
